// File: rtl/serial_alu.sv
// Slice-serial AND/OR/ADD/SUB/SLT: SLICE bits per cycle, LSB first, registered carry between slices.
// Define SERIAL_ALU_FLAGS_EN to compute zero/overflow/c_out; otherwise those outputs are tied to 0.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             c_out
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic [2:0]       op_reg;
  logic             carry_reg;
  logic             accept, last;

  logic [SLICE-1:0] sa, sb, sbx, sum_bits, slice_res;
  logic [SLICE:0]   chain;
  logic             is_arith, is_slt, is_or, ovf_int, slt_bit;

  assign last = (cnt_reg == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        accept     = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

  // Current slice of the captured operands
  assign sa  = a_reg[cnt_reg*SLICE +: SLICE];
  assign sb  = b_reg[cnt_reg*SLICE +: SLICE];
  assign sbx = op_reg[2] ? ~sb : sb;

  assign is_arith = (op_reg == 3'b010) || (op_reg == 3'b110) || (op_reg == 3'b111);
  assign is_slt   = (op_reg == 3'b111);
  assign is_or    = (op_reg == 3'b001);

  assign chain[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_ripple
      assign sum_bits[gi]  = sa[gi] ^ sbx[gi] ^ chain[gi];
      assign chain[gi+1]   = (sa[gi] & sbx[gi]) | (sa[gi] & chain[gi]) | (sbx[gi] & chain[gi]);
    end
  endgenerate

  assign slice_res = is_or ? (sa | sb) : (is_arith ? sum_bits : (sa & sb));
  // Signed overflow needs the carry into the MSB, which lives inside the last slice
  assign ovf_int   = chain[SLICE-1] ^ chain[SLICE];
  assign slt_bit   = sum_bits[SLICE-1] ^ ovf_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      op_reg     <= alu_op;
      carry_reg  <= alu_op[2];
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (state_reg == RUN) begin
      carry_reg <= chain[SLICE];
      cnt_reg   <= cnt_reg + CW'(1);
      if (last && is_slt)
        result_reg <= WIDTH'(slt_bit);
      else
        result_reg[cnt_reg*SLICE +: SLICE] <= slice_res;
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic is_addsub;
  logic zacc_reg, zero_reg, ovf_reg, cout_reg;

  assign is_addsub = (op_reg == 3'b010) || (op_reg == 3'b110);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zacc_reg <= 1'b0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      zacc_reg <= 1'b1;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      cout_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      zacc_reg <= zacc_reg & (slice_res == '0);
      if (last) begin
        zero_reg <= is_slt ? ~slt_bit : (zacc_reg & (slice_res == '0));
        ovf_reg  <= is_addsub & ovf_int;
        cout_reg <= is_addsub & chain[SLICE];
      end
    end
  end

  assign zero     = zero_reg;
  assign overflow = ovf_reg;
  assign c_out    = cout_reg;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
  assign c_out    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: reference model of ops/timing plus hand-computed vectors.
module tb_serial_alu;
  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int STEPS = WIDTH / SLICE;
`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  alu_op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero, overflow, c_out;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow), .c_out(c_out)
  );

  always #5 clk = ~clk;

  // op, a, b, result, zero, overflow, c_out (flag values as when flags are enabled)
  localparam int NV = 9;
  logic [2:0]  v_op  [NV] = '{3'b010, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000, 3'b001, 3'b011, 3'b010};
  logic [31:0] v_a   [NV] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0000000F, 32'hFFFFFFFF};
  logic [31:0] v_b   [NV] = '{32'h00000001, 32'd5, 32'd1, 32'h00000001, 32'h80000000,
                              32'hFF00FF00, 32'hFF00FF00, 32'h000000F0, 32'h00000001};
  logic [31:0] v_res [NV] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0,
                              32'hF000F000, 32'hFFF0FFF0, 32'h0, 32'h0};
  logic        v_z   [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        v_o   [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        v_c   [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic z, output logic o, output logic co);
    logic [32:0] s;
    r = '0; o = 1'b0; co = 1'b0;
    case (op)
      3'b001: r = x | y;
      3'b010: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[31:0];
        co = s[32];
        o  = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'b110: begin
        r  = x - y;
        co = (x >= y);
        o  = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = x & y;
    endcase
    z = (r == 32'd0);
    if (!FLAGS) begin
      z = 1'b0; o = 1'b0; co = 1'b0;
    end
  endfunction

  // Model: -1 = idle, 1..STEPS = busy cycles, STEPS+1 = done cycle
  int          mcnt = -1;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_z = 1'b0, m_o = 1'b0, m_c = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt = -1; m_res = '0; m_z = 1'b0; m_o = 1'b0; m_c = 1'b0;
    end else if ((mcnt == -1 || mcnt == STEPS + 1) && start) begin
      m_op = alu_op; m_a = a; m_b = b;
      m_res = '0; m_z = 1'b0; m_o = 1'b0; m_c = 1'b0;
      mcnt = 1;
    end else if (mcnt == STEPS + 1) begin
      mcnt = -1;
    end else if (mcnt == STEPS) begin
      model(m_op, m_a, m_b, m_res, m_z, m_o, m_c);
      mcnt = STEPS + 1;
    end else if (mcnt >= 1) begin
      mcnt = mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", {31'd0, busy}, {31'd0, (mcnt >= 1 && mcnt <= STEPS)});
      chk("done", {31'd0, done}, {31'd0, (mcnt == STEPS + 1)});
      if (mcnt == -1 || mcnt == STEPS + 1) begin
        chk("result", result, m_res);
        chk("zero", {31'd0, zero}, {31'd0, m_z});
        chk("overflow", {31'd0, overflow}, {31'd0, m_o});
        chk("c_out", {31'd0, c_out}, {31'd0, m_c});
      end
    end
  end

  task automatic run_op(input int i, input bit glitch);
    int lat;
    start = 1'b1; alu_op = v_op[i]; a = v_a[i]; b = v_b[i];
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 20 && !done) begin
      if (glitch) begin
        start = (lat == 4);
        if (lat == 4) begin
          a = ~a; b = 32'h12345678; alu_op = 3'b001;
        end
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    $display("[TB] op=%03b a=%08h b=%08h -> result=%08h z=%0b o=%0b c=%0b latency=%0d",
             v_op[i], v_a[i], v_b[i], result, zero, overflow, c_out, lat);
    chk("latency", 32'(lat), 32'(STEPS + 1));
    chk("lit_result", result, v_res[i]);
    chk("lit_zero", {31'd0, zero}, {31'd0, FLAGS & v_z[i]});
    chk("lit_overflow", {31'd0, overflow}, {31'd0, FLAGS & v_o[i]});
    chk("lit_c_out", {31'd0, c_out}, {31'd0, FLAGS & v_c[i]});
  endtask

  initial begin
    logic [31:0] r;
    logic z, o, co;

    for (int i = 0; i < NV; i++) begin
      model(v_op[i], v_a[i], v_b[i], r, z, o, co);
      chk("model_pin", r, v_res[i]);
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, zero, overflow, c_out}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Consecutive calls start in the done cycle, exercising back-to-back operation
    for (int i = 0; i < NV; i++) begin
      run_op(i, i == 5);
      if (i % 3 == 2) repeat (2) @(negedge clk);
    end

    // Reset in cycle 5 of a RUN
    start = 1'b1; alu_op = 3'b010; a = 32'hFFFFFFFF; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", {29'd0, zero, overflow, c_out}, 32'd0);
    $display("[TB] reset mid-run -> busy=%0b done=%0b result=%08h", busy, done, result);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(0, 1'b0);
    run_op(3, 1'b0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_alu.md
# serial_alu

Multi-cycle, slice-serial integer ALU: the parametrised successor of the one-bit ALU slice. It evaluates a WIDTH-bit AND/OR/ADD/SUB/SLT over WIDTH/SLICE clock cycles, processing SLICE bits per cycle LSB-first. A registered carry links consecutive slices. It sits between the datapath register file and the writeback stage in area-constrained configurations, using a start/done handshake in place of the fully combinational 32-bit ALU.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH.
- Derived: STEPS = WIDTH/SLICE.

Ports:
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when idle or in DONE.
- alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes behave as AND.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse when result/flags are valid.
- result  out  WIDTH  result, held until next accepted start.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only).
- c_out  out  1  carry out of MSB (ADD/SUB only).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs and internal registers are 0 at reset.
- IDLE/DONE + start=1: capture a, b, and alu_op; set the slice counter to 0; set carry to alu_op[2]; go to RUN. Clear result and flags at capture.
- RUN, each cycle: operate on bits [k*SLICE +: SLICE].
  - B is inverted when alu_op[2]=1.
  - AND/OR are bitwise.
  - ADD/SUB/SLT: slice sum = A + B' + carry. The slice carry-out is registered as the next carry.
- Result bits are written into result at slice position k; zero is accumulated as the AND of per-slice zero tests.
- Last slice (k = STEPS−1):
  - overflow = carry-into-MSB XOR carry-out, for ADD/SUB; 0 otherwise.
  - c_out = final carry for ADD/SUB; 0 otherwise.
  - SLT: result = {WIDTH-1 zeros, sum_msb XOR ovf_internal}, using the internal overflow. zero is recomputed from this result; overflow and c_out are reported 0.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle. Without start → IDLE; with start → accept a new operation (back-to-back).
- start while in RUN: ignored; operands are not re-sampled.
- reset_n low at any time, including mid-RUN: immediately IDLE, all outputs 0, the partial result is discarded.

## Timing
- start high in cycle 0 (accepted) → busy high in cycles 1..STEPS → done high in cycle STEPS+1.
- Latency STEPS+1 cycles from start to done. Throughput: one operation per STEPS+1 cycles with back-to-back start.
- result, zero, overflow, and c_out are valid from the done cycle and stable until the cycle after the next accepted start.
- busy and done are never high simultaneously.
- SLICE = WIDTH: STEPS = 1, and done follows start by 2 cycles.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: zero, overflow, and c_out are computed as above.
- SERIAL_ALU_FLAGS_EN undefined:
  - Flag logic is removed; zero, overflow, and c_out are tied to 0.
  - SLT still uses internal overflow for the correct signed comparison.
  - result and timing are unchanged.

## Test plan
- WIDTH=32, SLICE=4, ADD a=0x7FFFFFFF, b=0x00000001 → done in cycle 9; result 0x80000000, overflow=1, c_out=0, zero=0.
- SUB a=5, b=5 → result 0, zero=1, c_out=1, overflow=0. SUB a=0, b=1 → result 0xFFFFFFFF, c_out=0.
- SLT a=0xFFFFFFFF, b=1 → result 1. SLT a=0x7FFFFFFF, b=0x80000000 → result 0, and overflow output reads 0.
- AND/OR a=0xF0F0F0F0, b=0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0. Back-to-back start in the done cycle → second done exactly 9 cycles later.
- start pulsed in cycle 4 of a RUN → ignored, first result unaffected. reset_n dropped in cycle 5 → busy, done, result, and flags 0 immediately; next start works normally.
- Build without SERIAL_ALU_FLAGS_EN: repeat the first and third scenarios → result identical, flags constantly 0.
